// File: rtl/user_input_ctrl.sv
// user_input_ctrl: conditions the occupancy sensors and push-buttons for the toilet core
// (2-FF sync + debounce), tracks the user session and drives registered request levels.
// Optional build macro: USER_INPUT_AUTO_DEUR_EN adds the sit timer that classifies a
// session as defecation (reg_de_ur=1) once the user has been seated for SIT_CYCLES cycles.
`timescale 1ns/1ps
module user_input_ctrl #(
  parameter int DEB_CYCLES  = 4,
  parameter int HOLD_CYCLES = 20,
  parameter int SIT_CYCLES  = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_presence,
  input  logic raw_seat,
  input  logic btn_spray,
  input  logic btn_mode,
  input  logic btn_warm,
  input  logic count_drying_done,
  output logic reg_user_en,
  output logic reg_toilet_using,
  output logic reg_spray_en,
  output logic reg_spray_mode,
  output logic reg_de_ur,
  output logic warm_en
);

  localparam int NIN = 5;
  localparam logic [7:0] DEB_LAST  = 8'(DEB_CYCLES - 1);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRESENT = 3'd1,
    HOLD    = 3'd2,
    SEATED  = 3'd3,
    WASH    = 3'd4
  } state_t;

  // Input bit order: 0 presence, 1 seat, 2 spray, 3 mode, 4 warm
  logic [NIN-1:0] w_raw;
  logic [NIN-1:0] r_sync1;
  logic [NIN-1:0] r_sync2;
  logic [NIN-1:0] r_deb;
  logic [7:0]     r_debCnt [NIN];
  logic [2:0]     r_btnDly;
  logic [2:0]     w_press;
  logic           w_presence;
  logic           w_seat;
  logic           w_pressSpray;
  logic           w_pressMode;
  logic           w_pressWarm;
  logic           w_holdDone;
  logic [7:0]     r_holdCnt;
  state_t         r_state;
  state_t         w_next;

  assign w_raw = {btn_warm, btn_mode, btn_spray, raw_seat, raw_presence};

  // Two-flop synchroniser for every asynchronous input
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debouncers: the clean value flips once the synchronised input has disagreed for DEB_CYCLES cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      r_deb <= '0;
      for (int i = 0; i < NIN; i++) r_debCnt[i] <= '0;
    end else begin
      for (int i = 0; i < NIN; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_debCnt[i] <= '0;
        end else if (r_debCnt[i] == DEB_LAST) begin
          r_deb[i]    <= r_sync2[i];
          r_debCnt[i] <= '0;
        end else begin
          r_debCnt[i] <= r_debCnt[i] + 8'd1;
        end
      end
    end
  end

  // Delayed copies of the debounced buttons so each press yields a single-cycle pulse
  always_ff @(posedge clk) begin
    if (reset) r_btnDly <= '0;
    else       r_btnDly <= r_deb[4:2];
  end

  assign w_press      = r_deb[4:2] & ~r_btnDly;
  assign w_pressSpray = w_press[0];
  assign w_pressMode  = w_press[1];
  assign w_pressWarm  = w_press[2];
  assign w_presence   = r_deb[0];
  assign w_seat       = r_deb[1];
  assign w_holdDone   = (r_holdCnt == HOLD_LAST);

  // Session next-state decision; the if-chains encode the event priorities in HOLD and WASH
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_presence) w_next = PRESENT;
      end
      PRESENT: begin
        if (w_seat)           w_next = SEATED;
        else if (!w_presence) w_next = HOLD;
      end
      HOLD: begin
        if (w_seat)          w_next = SEATED;
        else if (w_presence) w_next = PRESENT;
        else if (w_holdDone) w_next = IDLE;
      end
      SEATED: begin
        if (!w_seat)           w_next = PRESENT;
        else if (w_pressSpray) w_next = WASH;
      end
      WASH: begin
        if (!w_seat)                w_next = PRESENT;
        else if (count_drying_done) w_next = SEATED;
        else if (w_pressSpray)      w_next = SEATED;
      end
      default: w_next = IDLE;
    endcase
  end

  // Session state, hold timer and request outputs, all registered from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= IDLE;
      r_holdCnt        <= '0;
      reg_user_en      <= 1'b0;
      reg_toilet_using <= 1'b0;
      reg_spray_en     <= 1'b0;
      reg_spray_mode   <= 1'b0;
      warm_en          <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == HOLD) && (w_next == HOLD)) r_holdCnt <= r_holdCnt + 8'd1;
      else                                       r_holdCnt <= '0;
      reg_user_en      <= (w_next != IDLE);
      reg_toilet_using <= (w_next == SEATED) || (w_next == WASH);
      reg_spray_en     <= (w_next == WASH);
      if (w_next == IDLE)                          reg_spray_mode <= 1'b0;
      else if (w_pressMode && (r_state != IDLE))   reg_spray_mode <= ~reg_spray_mode;
      if (w_pressWarm) warm_en <= ~warm_en;
    end
  end

`ifdef USER_INPUT_AUTO_DEUR_EN
  localparam logic [15:0] SIT_LIM = 16'(SIT_CYCLES);

  logic [15:0] r_sitCnt;
  logic        r_deUr;
  logic        w_seatedNow;

  assign w_seatedNow = (r_state == SEATED) || (r_state == WASH);

  // Sit timer restarts when the user sits down; the classification latches until the session ends
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sitCnt <= '0;
      r_deUr   <= 1'b0;
    end else begin
      if ((w_next == SEATED) && ((r_state == PRESENT) || (r_state == HOLD)))
        r_sitCnt <= '0;
      else if (w_seatedNow && (r_sitCnt != 16'hFFFF))
        r_sitCnt <= r_sitCnt + 16'd1;
      if (w_next == IDLE)
        r_deUr <= 1'b0;
      else if (w_seatedNow && (r_sitCnt >= SIT_LIM))
        r_deUr <= 1'b1;
    end
  end

  assign reg_de_ur = r_deUr;
`else
  // Without the sit timer every session is treated as urination; SIT_CYCLES has no effect
  assign reg_de_ur = 1'b0 & (SIT_CYCLES != 0);
`endif

endmodule

// File: tb/tb_user_input_ctrl.sv
// tb_user_input_ctrl: directed test of user_input_ctrl with default parameters.
// Expected reg_de_ur for long sits follows the USER_INPUT_AUTO_DEUR_EN build macro.
`timescale 1ns/1ps
module tb_user_input_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic raw_presence = 1'b0;
  logic raw_seat = 1'b0;
  logic btn_spray = 1'b0;
  logic btn_mode = 1'b0;
  logic btn_warm = 1'b0;
  logic count_drying_done = 1'b0;
  logic reg_user_en;
  logic reg_toilet_using;
  logic reg_spray_en;
  logic reg_spray_mode;
  logic reg_de_ur;
  logic warm_en;

  int checkCount = 0;
  int passCount = 0;

`ifdef USER_INPUT_AUTO_DEUR_EN
  localparam logic EXP_DEUR = 1'b1;
`else
  localparam logic EXP_DEUR = 1'b0;
`endif

  user_input_ctrl #(
    .DEB_CYCLES (4),
    .HOLD_CYCLES(20),
    .SIT_CYCLES (100)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .raw_presence     (raw_presence),
    .raw_seat         (raw_seat),
    .btn_spray        (btn_spray),
    .btn_mode         (btn_mode),
    .btn_warm         (btn_warm),
    .count_drying_done(count_drying_done),
    .reg_user_en      (reg_user_en),
    .reg_toilet_using (reg_toilet_using),
    .reg_spray_en     (reg_spray_en),
    .reg_spray_mode   (reg_spray_mode),
    .reg_de_ur        (reg_de_ur),
    .warm_en          (warm_en)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 ns past the last one
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold a button long enough to register one press (press acts at edge 6), then release and settle
  task automatic pressButton(input int which);
    case (which)
      0:       btn_spray = 1'b1;
      1:       btn_mode  = 1'b1;
      default: btn_warm  = 1'b1;
    endcase
    tick(7);
    btn_spray = 1'b0;
    btn_mode  = 1'b0;
    btn_warm  = 1'b0;
    tick(10);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(2);
    checkCount++;
    if ({reg_user_en, reg_toilet_using, reg_spray_en, reg_spray_mode, reg_de_ur, warm_en} !== 6'b000000)
      $display("[TB] FAIL reset_outputs: got %b expected %b",
               {reg_user_en, reg_toilet_using, reg_spray_en, reg_spray_mode, reg_de_ur, warm_en}, 6'b000000);
    else passCount++;
    reset = 1'b0;
    raw_seat = 1'b1;
    tick(20);
    checkCount++;
    if ({reg_user_en, reg_toilet_using, reg_spray_en, reg_spray_mode, reg_de_ur, warm_en} !== 6'b000000)
      $display("[TB] FAIL seat_without_presence: got %b expected %b",
               {reg_user_en, reg_toilet_using, reg_spray_en, reg_spray_mode, reg_de_ur, warm_en}, 6'b000000);
    else passCount++;
    raw_seat = 1'b0;
    tick(10);
  endtask

  task automatic test_session;
    raw_presence = 1'b1;
    tick(6);
    checkCount++;
    if (reg_user_en !== 1'b0) $display("[TB] FAIL presence_edge5: got %b expected %b", reg_user_en, 1'b0);
    else passCount++;
    tick(1);
    checkCount++;
    if ({reg_user_en, reg_toilet_using} !== 2'b10)
      $display("[TB] FAIL presence_edge6: got %b expected %b", {reg_user_en, reg_toilet_using}, 2'b10);
    else passCount++;
    raw_seat = 1'b1;
    tick(6);
    checkCount++;
    if (reg_toilet_using !== 1'b0) $display("[TB] FAIL seat_edge5: got %b expected %b", reg_toilet_using, 1'b0);
    else passCount++;
    tick(1);
    checkCount++;
    if (reg_toilet_using !== 1'b1) $display("[TB] FAIL seat_edge6: got %b expected %b", reg_toilet_using, 1'b1);
    else passCount++;
    raw_presence = 1'b0;
    tick(12);
    checkCount++;
    if ({reg_user_en, reg_toilet_using} !== 2'b11)
      $display("[TB] FAIL presence_drop_seated: got %b expected %b", {reg_user_en, reg_toilet_using}, 2'b11);
    else passCount++;
    raw_presence = 1'b1;
    tick(10);
    raw_seat = 1'b0;
    tick(7);
    checkCount++;
    if ({reg_user_en, reg_toilet_using} !== 2'b10)
      $display("[TB] FAIL stand_up: got %b expected %b", {reg_user_en, reg_toilet_using}, 2'b10);
    else passCount++;
    // debounced presence falls at edge 5, so the session must end at edge 26
    raw_presence = 1'b0;
    tick(26);
    checkCount++;
    if (reg_user_en !== 1'b1) $display("[TB] FAIL hold_edge25: got %b expected %b", reg_user_en, 1'b1);
    else passCount++;
    tick(1);
    checkCount++;
    if (reg_user_en !== 1'b0) $display("[TB] FAIL hold_expiry_edge26: got %b expected %b", reg_user_en, 1'b0);
    else passCount++;
    // presence returning during HOLD must keep the session alive
    raw_presence = 1'b1;
    tick(10);
    raw_presence = 1'b0;
    tick(12);
    raw_presence = 1'b1;
    tick(30);
    checkCount++;
    if (reg_user_en !== 1'b1) $display("[TB] FAIL hold_return: got %b expected %b", reg_user_en, 1'b1);
    else passCount++;
    raw_presence = 1'b0;
    tick(30);
  endtask

  task automatic test_glitch;
    raw_presence = 1'b1;
    raw_seat = 1'b1;
    tick(14);
    checkCount++;
    if (reg_toilet_using !== 1'b1) $display("[TB] FAIL glitch_setup_seated: got %b expected %b", reg_toilet_using, 1'b1);
    else passCount++;
    btn_spray = 1'b1;
    tick(3);
    btn_spray = 1'b0;
    tick(12);
    checkCount++;
    if (reg_spray_en !== 1'b0) $display("[TB] FAIL glitch_3cyc: got %b expected %b", reg_spray_en, 1'b0);
    else passCount++;
    btn_spray = 1'b1;
    tick(4);
    btn_spray = 1'b0;
    tick(2);
    checkCount++;
    if (reg_spray_en !== 1'b0) $display("[TB] FAIL pulse_4cyc_edge5: got %b expected %b", reg_spray_en, 1'b0);
    else passCount++;
    tick(1);
    checkCount++;
    if (reg_spray_en !== 1'b1) $display("[TB] FAIL pulse_4cyc_edge6: got %b expected %b", reg_spray_en, 1'b1);
    else passCount++;
    tick(10);
  endtask

  task automatic test_wash;
    count_drying_done = 1'b1;
    tick(1);
    count_drying_done = 1'b0;
    checkCount++;
    if ({reg_toilet_using, reg_spray_en} !== 2'b10)
      $display("[TB] FAIL drying_done: got %b expected %b", {reg_toilet_using, reg_spray_en}, 2'b10);
    else passCount++;
    pressButton(0);
    checkCount++;
    if (reg_spray_en !== 1'b1) $display("[TB] FAIL wash_again: got %b expected %b", reg_spray_en, 1'b1);
    else passCount++;
    pressButton(0);
    checkCount++;
    if ({reg_toilet_using, reg_spray_en} !== 2'b10)
      $display("[TB] FAIL spray_cancel: got %b expected %b", {reg_toilet_using, reg_spray_en}, 2'b10);
    else passCount++;
    pressButton(0);
    // debounced seat falls at edge 5; drying-done arrives on edge 6 together with it
    raw_seat = 1'b0;
    tick(6);
    count_drying_done = 1'b1;
    tick(1);
    count_drying_done = 1'b0;
    checkCount++;
    if ({reg_user_en, reg_toilet_using, reg_spray_en} !== 3'b100)
      $display("[TB] FAIL seat_low_beats_done: got %b expected %b",
               {reg_user_en, reg_toilet_using, reg_spray_en}, 3'b100);
    else passCount++;
  endtask

  task automatic test_toggles;
    pressButton(1);
    checkCount++;
    if (reg_spray_mode !== 1'b1) $display("[TB] FAIL mode_first: got %b expected %b", reg_spray_mode, 1'b1);
    else passCount++;
    pressButton(1);
    checkCount++;
    if (reg_spray_mode !== 1'b0) $display("[TB] FAIL mode_second: got %b expected %b", reg_spray_mode, 1'b0);
    else passCount++;
    pressButton(1);
    raw_presence = 1'b0;
    tick(35);
    checkCount++;
    if ({reg_user_en, reg_spray_mode} !== 2'b00)
      $display("[TB] FAIL mode_clear_idle: got %b expected %b", {reg_user_en, reg_spray_mode}, 2'b00);
    else passCount++;
    pressButton(1);
    checkCount++;
    if (reg_spray_mode !== 1'b0) $display("[TB] FAIL mode_idle_ignored: got %b expected %b", reg_spray_mode, 1'b0);
    else passCount++;
    pressButton(2);
    checkCount++;
    if (warm_en !== 1'b1) $display("[TB] FAIL warm_idle: got %b expected %b", warm_en, 1'b1);
    else passCount++;
  endtask

  task automatic test_reset_midsession;
    raw_presence = 1'b1;
    raw_seat = 1'b1;
    tick(14);
    pressButton(0);
    checkCount++;
    if ({reg_user_en, reg_toilet_using, reg_spray_en, warm_en} !== 4'b1111)
      $display("[TB] FAIL pre_reset_session: got %b expected %b",
               {reg_user_en, reg_toilet_using, reg_spray_en, warm_en}, 4'b1111);
    else passCount++;
    reset = 1'b1;
    tick(1);
    checkCount++;
    if ({reg_user_en, reg_toilet_using, reg_spray_en, reg_spray_mode, reg_de_ur, warm_en} !== 6'b000000)
      $display("[TB] FAIL reset_midsession: got %b expected %b",
               {reg_user_en, reg_toilet_using, reg_spray_en, reg_spray_mode, reg_de_ur, warm_en}, 6'b000000);
    else passCount++;
    reset = 1'b0;
    raw_presence = 1'b0;
    raw_seat = 1'b0;
    tick(10);
  endtask

  task automatic test_deur;
    // seated from edge 7 onward
    raw_presence = 1'b1;
    raw_seat = 1'b1;
    tick(57);
    checkCount++;
    if (reg_de_ur !== 1'b0) $display("[TB] FAIL deur_short_sit: got %b expected %b", reg_de_ur, 1'b0);
    else passCount++;
    tick(100);
    checkCount++;
    if (reg_de_ur !== EXP_DEUR) $display("[TB] FAIL deur_long_sit: got %b expected %b", reg_de_ur, EXP_DEUR);
    else passCount++;
    raw_seat = 1'b0;
    tick(10);
    checkCount++;
    if ({reg_user_en, reg_de_ur} !== {1'b1, EXP_DEUR})
      $display("[TB] FAIL deur_held_standing: got %b expected %b", {reg_user_en, reg_de_ur}, {1'b1, EXP_DEUR});
    else passCount++;
    raw_presence = 1'b0;
    tick(40);
    checkCount++;
    if ({reg_user_en, reg_de_ur} !== 2'b00)
      $display("[TB] FAIL deur_clear_idle: got %b expected %b", {reg_user_en, reg_de_ur}, 2'b00);
    else passCount++;
  endtask

  // Run every scenario in order, then report
  initial begin
    test_reset();
    test_session();
    test_glitch();
    test_wash();
    test_toggles();
    test_reset_midsession();
    test_deur();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/user_input_ctrl.md
# user_input_ctrl

Front-end conditioning stage feeding the toilet control `core`. Samples raw occupancy sensors and user push-buttons, synchronises and debounces them, tracks the user session in a small state machine, and drives the `core` request levels `reg_user_en`, `reg_toilet_using`, `reg_spray_en`, `reg_spray_mode`, `reg_de_ur` and `warm_en`. It consumes `count_drying_done` from `core` to close a wash cycle.

## Interface
- `DEB_CYCLES`, 4: consecutive stable cycles required before a debounced input changes (1..255).
- `HOLD_CYCLES`, 20: cycles `reg_user_en` is held after presence is lost (1..255).
- `SIT_CYCLES`, 100: seated cycles at or above which a session is classed as defecation (1..65535).
- `clk` in 1: single clock, all logic on its rising edge.
- `reset` in 1: synchronous, active-high; one cycle asserted is sufficient.
- `raw_presence` in 1: IR user-presence sensor, asynchronous.
- `raw_seat` in 1: seat pressure sensor, asynchronous.
- `btn_spray` in 1: spray button, asynchronous, active-high.
- `btn_mode` in 1: spray-mode button, asynchronous.
- `btn_warm` in 1: seat-warm button, asynchronous.
- `count_drying_done` in 1: one-cycle pulse from `core` marking the end of drying.
- `reg_user_en` out 1: user session active.
- `reg_toilet_using` out 1: user seated.
- `reg_spray_en` out 1: wash requested.
- `reg_spray_mode` out 1: 0 = rear, 1 = front.
- `reg_de_ur` out 1: 1 = defecation, 0 = urination.
- `warm_en` out 1: seat heating request.

## Operation
- Each raw input passes through a 2-FF synchroniser, then a per-input debouncer. Each debouncer has an 8-bit counter that increments while the synchronised value differs from the debounced value and clears on a match. When the counter reaches `DEB_CYCLES`, the debounced value flips and the counter clears.
- Button press = debounced rising edge (debounced value AND NOT its one-cycle-delayed copy). A press lasts exactly one cycle per physical press.
- Session FSM states:
  - IDLE
    - Presence high -> PRESENT.
  - PRESENT
    - Seat high -> SEATED.
    - Presence low -> HOLD, hold counter cleared.
  - HOLD
    - Presence high -> PRESENT.
    - Seat high -> SEATED.
    - Otherwise the counter increments; on reaching `HOLD_CYCLES` -> IDLE.
  - SEATED
    - Spray press -> WASH.
    - Seat low -> PRESENT.
  - WASH
    - `count_drying_done` -> SEATED.
    - Spray press -> SEATED (cancel).
    - Seat low -> PRESENT.
- Outputs are registered, decoded from the next state:
  - `reg_user_en` = 1 in every state except IDLE.
  - `reg_toilet_using` = 1 in SEATED and WASH.
  - `reg_spray_en` = 1 in WASH only.
- Seat-high while presence is low (IDLE) is ignored; there is no session without presence.
- `reg_spray_mode` toggles on a mode press while not IDLE. It clears to 0 on entry to IDLE.
- `warm_en` toggles on a warm press in any state. It is unaffected by the session.
- Simultaneous events in WASH: seat low has priority over `count_drying_done`, which has priority over a spray press.
- Simultaneous events in HOLD: seat high has priority over presence high, which has priority over hold expiry.

## Timing
- Reset values: all outputs 0, FSM in IDLE, all counters 0, debounced values 0, synchronisers 0.
- A raw change first sampled at edge 0:
  - The debounced value flips at edge `DEB_CYCLES`+1.
  - Outputs change at edge `DEB_CYCLES`+2, which is edge 6 for the defaults.
- A glitch shorter than `DEB_CYCLES` synchronised cycles produces no output change.
- `count_drying_done` is used directly, not synchronised. `reg_spray_en` falls on the edge following the pulse.
- HOLD expiry: `reg_user_en` falls `HOLD_CYCLES`+1 edges after the debounced presence falls.
- Reset asserted mid-session forces IDLE with all outputs 0 on that edge, including `warm_en`.

## Configuration
- `USER_INPUT_AUTO_DEUR_EN` defined:
  - A 16-bit sit counter clears on entry to SEATED from PRESENT or HOLD and increments, saturating, while in SEATED or WASH.
  - `reg_de_ur` is set when the count reaches `SIT_CYCLES` and is held until entry to IDLE.
- Not defined: the sit counter is absent and `reg_de_ur` is constant 0.

## Test plan
- Reset: assert `reset` 2 cycles -> all outputs 0. Hold `raw_seat`=1 with presence 0 -> outputs stay 0.
- Session, defaults: presence 1 at edge 0 -> `reg_user_en`=1 at edge 6. Seat 1 -> `reg_toilet_using`=1 6 edges later. Presence 0 while seated -> no change. Seat 0 then 25 idle cycles -> `reg_user_en` falls exactly 21 edges after debounced presence falls.
- Glitch: 3-cycle pulse on `btn_spray` while seated -> `reg_spray_en` stays 0. 4-cycle pulse -> `reg_spray_en`=1.
- Wash: seated, spray press -> `reg_spray_en`=1. `count_drying_done` pulse -> 0 next edge. Repeat, then seat 0 in the same cycle as `count_drying_done` -> PRESENT, `reg_spray_en`=0, `reg_toilet_using`=0.
- Toggles: two mode presses -> `reg_spray_mode` 1 then 0. Mode press in IDLE -> no change. Warm press in IDLE -> `warm_en`=1.
- With `USER_INPUT_AUTO_DEUR_EN` and `SIT_CYCLES`=100:
  - Sit 50 cycles -> `reg_de_ur`=0.
  - Sit 150 cycles -> `reg_de_ur`=1 until IDLE.
  - Without the macro -> always 0.
